// File: rtl/xmpl_loongson_pkg.sv
// Shared types and constants for the xmpl_loongson command transmitter.
package xmpl_loongson_pkg;

    localparam int ADDR_W          = 12;
    localparam int DATA_W          = 32;
    localparam int STATUS_DONE_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    function automatic logic status_done(input logic [DATA_W-1:0] status);
        return status[STATUS_DONE_BIT];
    endfunction

endpackage

// File: rtl/xmpl_loongson_cmd_tx_if.sv
// Command, core and response signals of the transmitter, named from the transmitter's side.
interface xmpl_loongson_cmd_tx_if;
    import xmpl_loongson_pkg::*;

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              xmpl_loongson_a_o;
    logic [ADDR_W-1:0] xmpl_loongson_b_o;
    logic [DATA_W-1:0] xmpl_loongson_c_o;
    logic [DATA_W-1:0] xmpl_loongson_status_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_status_o;
    logic              rsp_timeout_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, xmpl_loongson_status_i, rsp_ready_i,
        output cmd_ready_o, xmpl_loongson_a_o, xmpl_loongson_b_o, xmpl_loongson_c_o,
               rsp_valid_o, rsp_status_o, rsp_timeout_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, xmpl_loongson_status_i, rsp_ready_i,
        input  cmd_ready_o, xmpl_loongson_a_o, xmpl_loongson_b_o, xmpl_loongson_c_o,
               rsp_valid_o, rsp_status_o, rsp_timeout_o
    );

endinterface

// File: rtl/xmpl_loongson_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rdata_o while not empty.
module xmpl_loongson_cmd_fifo #(
    parameter int  WIDTH = 44,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: storage is deliberately left out of reset; an entry is only read after it was written,
    // so resetting it would just add reset fan-out to every bit of the array.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/xmpl_loongson_cmd_tx.sv
// Buffers upstream commands and issues them one at a time to the xmpl_loongson core,
// returning one response per command on completion or timeout.
module xmpl_loongson_cmd_tx
    import xmpl_loongson_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    xmpl_loongson_cmd_tx_if.slave  bus
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    state_t              state_q;
    logic                a_q;
    logic [ADDR_W-1:0]   b_q;
    logic [DATA_W-1:0]   c_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_status_q;
    logic                rsp_timeout_q;

    cmd_t                cmd_in;
    cmd_t                fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;

    assign cmd_in.addr     = bus.cmd_addr_i;
    assign cmd_in.data     = bus.cmd_data_i;
    assign bus.cmd_ready_o = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push            = bus.cmd_valid_i && !fifo_full;
    assign pop             = (state_q == ST_IDLE) && !fifo_empty;

    xmpl_loongson_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .wdata_i   (cmd_in),
        .pop_i     (pop),
        .rdata_o   (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // NOTE: every register here is assigned with <= so all updates see the pre-edge values;
    // mixing in = would make the result depend on statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            a_q           <= 1'b0;
            b_q           <= '0;
            c_q           <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            a_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        b_q     <= fifo_head.addr;
                        c_q     <= fifo_head.data;
                        a_q     <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer_q != {TIMER_W{1'b1}}) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    // Done wins when it arrives on the same cycle the timer expires.
                    if (status_done(bus.xmpl_loongson_status_i)) begin
                        rsp_status_q  <= bus.xmpl_loongson_status_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                        rsp_status_q  <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.xmpl_loongson_a_o = a_q;
    assign bus.xmpl_loongson_b_o = b_q;
    assign bus.xmpl_loongson_c_o = c_q;
    assign bus.rsp_valid_o       = rsp_valid_q;
    assign bus.rsp_status_o      = rsp_status_q;
    assign bus.rsp_timeout_o     = rsp_timeout_q;

endmodule

// File: tb/tb_xmpl_loongson_cmd_tx.sv
// Scoreboard bench for xmpl_loongson_cmd_tx: directed commands queue their expected issue and
// response; a negedge monitor checks strobes, latencies and responses as the DUT presents them.
module tb_xmpl_loongson_cmd_tx;
    import xmpl_loongson_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic [31:0] status;
        logic        timeout;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    xmpl_loongson_cmd_tx_if bus();

    xmpl_loongson_cmd_tx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_t exp_cmd_q [$];
    rsp_t exp_rsp_q [$];
    int   exp_lat_q [$];

    int          core_delay  = 0;
    logic [31:0] core_status = '0;

    int          strobe_cyc  = -100;
    int          push_cyc    = -100;
    int          last_hs_cyc = -100;
    int          n_strobes   = 0;
    bit          chk_issue   = 0;
    logic        prev_a      = 1'b0;
    logic        prev_rv     = 1'b0;
    logic [31:0] prev_st     = '0;
    logic        prev_to     = 1'b0;
    cmd_t        mon_cmd;
    rsp_t        mon_rsp;
    int          mon_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: raises done with core_status for one cycle, core_delay cycles after the strobe.
    always begin
        @(negedge clk);
        if (rst_n && bus.xmpl_loongson_a_o && core_delay > 0) begin
            repeat (core_delay) @(posedge clk);
            #1 bus.xmpl_loongson_status_i = core_status;
            @(posedge clk);
            #1 bus.xmpl_loongson_status_i = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_a  = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) push_cyc = cyc;
            if (prev_a) check("a_one_cycle", bus.xmpl_loongson_a_o, 0);
            if (bus.xmpl_loongson_a_o) begin
                strobe_cyc = cyc;
                n_strobes++;
                check("strobe_expected", exp_cmd_q.size() > 0, 1);
                if (exp_cmd_q.size() > 0) begin
                    mon_cmd = exp_cmd_q.pop_front();
                    check("issue_addr", bus.xmpl_loongson_b_o, mon_cmd.addr);
                    check("issue_data", bus.xmpl_loongson_c_o, mon_cmd.data);
                end
                check("one_outstanding", bus.rsp_valid_o, 0);
                check("b2b_gap", (cyc - last_hs_cyc) >= 2, 1);
                if (chk_issue) begin
                    check("issue_latency", cyc - push_cyc, 2);
                    chk_issue = 0;
                end
            end
            if (bus.rsp_valid_o && !prev_rv) begin
                check("rsp_rise_expected", exp_lat_q.size() > 0, 1);
                if (exp_lat_q.size() > 0) begin
                    mon_lat = exp_lat_q.pop_front();
                    check("rsp_latency", cyc - strobe_cyc, mon_lat);
                end
            end
            if (bus.rsp_valid_o && prev_rv) begin
                check("rsp_status_stable", bus.rsp_status_o, prev_st);
                check("rsp_timeout_stable", bus.rsp_timeout_o, prev_to);
            end
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                last_hs_cyc = cyc;
                check("rsp_expected", exp_rsp_q.size() > 0, 1);
                if (exp_rsp_q.size() > 0) begin
                    mon_rsp = exp_rsp_q.pop_front();
                    check("rsp_status", bus.rsp_status_o, mon_rsp.status);
                    check("rsp_timeout", bus.rsp_timeout_o, mon_rsp.timeout);
                end
            end
            prev_a  = bus.xmpl_loongson_a_o;
            prev_rv = bus.rsp_valid_o;
            prev_st = bus.rsp_status_o;
            prev_to = bus.rsp_timeout_o;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
        check({tag, "_a"}, bus.xmpl_loongson_a_o, 0);
        check({tag, "_b"}, bus.xmpl_loongson_b_o, 0);
        check({tag, "_c"}, bus.xmpl_loongson_c_o, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        check({tag, "_rsp_status"}, bus.rsp_status_o, 0);
        check({tag, "_rsp_timeout"}, bus.rsp_timeout_o, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input logic [11:0] a, input logic [31:0] d, input logic [31:0] st,
                            input logic to, input int lat, output int acc);
        exp_cmd_q.push_back(cmd_t'{a, d});
        exp_rsp_q.push_back(rsp_t'{st, to});
        exp_lat_q.push_back(lat);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = a;
        bus.cmd_data_i  = d;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) acc = cyc;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid_i = 1'b0;
        check("push_accepted", acc >= 0, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_rsp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check({"drain_", name}, exp_rsp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_burst [6];
        int s0;

        bus.cmd_valid_i            = 1'b0;
        bus.cmd_addr_i             = '0;
        bus.cmd_data_i             = '0;
        bus.xmpl_loongson_status_i = '0;
        bus.rsp_ready_i            = 1'b1;

        #1 rst_n = 1'b0;
        #2 check_reset_vals("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command, done three cycles after the strobe.
        core_delay  = 3;
        core_status = 32'h0000_0013;
        chk_issue   = 1;
        push_cmd(12'h0A5, 32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 4, acc);
        drain("single");
        check("b_held", bus.xmpl_loongson_b_o, 12'h0A5);
        check("c_held", bus.xmpl_loongson_c_o, 32'hDEAD_BEEF);

        // Timeout with no done.
        core_delay = 0;
        push_cmd(12'h123, 32'h0123_4567, 32'h0, 1'b1, TMO + 1, acc);
        drain("timeout");

        // FIFO full: one in flight plus DEPTH buffered, sixth waits for the first response.
        core_delay = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(12'(12'h100 + i), 32'(32'hA000_0000 + i), 32'h0, 1'b1, TMO + 1, acc_burst[i]);
            if (i == 4) check("ready_low_after_5th", bus.cmd_ready_o, 0);
        end
        check("sixth_accept_after_rsp", acc_burst[5] - last_hs_cyc, 2);
        drain("full");

        // Response backpressure for 10 cycles with a second command queued.
        bus.rsp_ready_i = 1'b0;
        core_delay      = 2;
        core_status     = 32'h0000_5555;
        s0              = n_strobes;
        push_cmd(12'h2AA, 32'h5555_AAAA, 32'h0000_5555, 1'b0, 3, acc);
        push_cmd(12'h355, 32'hAAAA_5555, 32'h0000_5555, 1'b0, 3, acc);
        for (int i = 0; i < 50 && !bus.rsp_valid_o; i++) begin
            @(posedge clk);
            #1;
        end
        check("bp_rsp_seen", bus.rsp_valid_o, 1);
        repeat (10) @(posedge clk);
        #1;
        check("bp_valid_held", bus.rsp_valid_o, 1);
        check("bp_no_new_strobe", n_strobes - s0, 1);
        bus.rsp_ready_i = 1'b1;
        drain("backpressure");

        // Done on the last WAIT cycle wins over the timeout.
        core_delay  = TMO;
        core_status = 32'hCAFE_0001;
        push_cmd(12'h7FF, 32'hFFFF_FFFF, 32'hCAFE_0001, 1'b0, TMO + 1, acc);
        drain("done_on_timeout");

        // Done one cycle too late: timeout already taken, done during RESP is ignored.
        core_delay  = TMO + 1;
        core_status = 32'h0000_0F01;
        push_cmd(12'h001, 32'h0000_0001, 32'h0, 1'b1, TMO + 1, acc);
        drain("done_late");

        // Asynchronous reset while waiting for done.
        core_delay = 0;
        s0         = n_strobes;
        push_cmd(12'h055, 32'h0F0F_0F0F, 32'h0, 1'b1, TMO + 1, acc);
        for (int i = 0; i < 20 && n_strobes == s0; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_cmd_issued", n_strobes - s0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_wait");
        exp_rsp_q.delete();
        exp_lat_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        s0 = n_strobes;
        repeat (15) @(posedge clk);
        #1;
        check("rst_no_rsp", bus.rsp_valid_o, 0);
        check("rst_no_strobe", n_strobes - s0, 0);
        core_delay  = 1;
        core_status = 32'h0000_0003;
        push_cmd(12'h3C3, 32'h1357_9BDF, 32'h0000_0003, 1'b0, 2, acc);
        drain("after_reset");

        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("lat_q_empty", exp_lat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xmpl_loongson_cmd_tx.md
# xmpl_loongson_cmd_tx

Command transmitter for the xmpl_loongson core: accepts commands from an upstream master over valid/ready, buffers them, and drives the core's strobe, address and data inputs one command at a time. Each issued command waits for the core's done bit on its status word, or for a timeout. One response is then returned upstream. Sits between the system-side command source and the xmpl_loongson instance, as the initiator end of its input interface.

## Interface
Parameters:
- FIFO_DEPTH, 4, command buffer entries; power of two, >= 2.
- TIMEOUT, 255, maximum cycles to wait for done after the strobe; >= 1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  upstream command valid.
- cmd_ready_o  output  1  buffer can accept; equals buffer not full.
- cmd_addr_i  input  12  command address/opcode.
- cmd_data_i  input  32  command data.
- xmpl_loongson_a_o  output  1  one-cycle issue strobe to the core.
- xmpl_loongson_b_o  output  12  address to the core; held between issues.
- xmpl_loongson_c_o  output  32  data to the core; held between issues.
- xmpl_loongson_status_i  input  32  core status; bit 0 = done, bits 31:1 = result.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  upstream accepts response.
- rsp_status_o  output  32  captured status word; 0 on timeout.
- rsp_timeout_o  output  1  response produced by timeout.

## Operation
- Command buffer: FIFO of {addr, data}, FIFO_DEPTH entries.
  - Push on cmd_valid_i && cmd_ready_o. Pop when the FSM leaves IDLE.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged. Push while full cannot occur, since cmd_ready_o = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty -> pop head into b/c output registers, go to ISSUE.
  - ISSUE: a_o = 1 for exactly this cycle; clear timer; go to WAIT.
  - WAIT: timer increments each cycle.
    - status_i[0] = 1 -> capture full status_i into rsp_status_o, set rsp_timeout_o = 0, go to RESP.
    - Otherwise, timer == TIMEOUT-1 -> set rsp_status_o = 0 and rsp_timeout_o = 1, go to RESP.
    - Done takes priority over timeout in the same cycle.
  - RESP: rsp_valid_o = 1, with rsp_status_o and rsp_timeout_o stable. rsp_valid_o && rsp_ready_i -> IDLE.
- Only one command is outstanding at a time. Upstream may keep pushing during WAIT and RESP until the FIFO is full.
- status_i is ignored outside WAIT, including during the ISSUE cycle.
- Timer width is $clog2(TIMEOUT+1). The timer saturates and never wraps.
- Reset mid-operation clears the FIFO, the FSM and the response. The in-flight command is dropped and no response is produced.

## Timing
- Reset values:
  - cmd_ready_o = 1 (count = 0).
  - a_o = 0, b_o = 0, c_o = 0.
  - rsp_valid_o = 0, rsp_status_o = 0, rsp_timeout_o = 0.
  - FSM = IDLE.
- Issue latency: a command accepted at edge E0 into an empty FIFO with the FSM in IDLE gives a_o = 1 in the cycle after E1. That is 2 cycles from handshake to strobe.
- Response latency: done sampled at edge Ed gives rsp_valid_o = 1 in the cycle following Ed.
- Timeout: with no done, rsp_valid_o rises TIMEOUT+1 cycles after the strobe cycle.
- Back-to-back: after a response handshake at edge Er, the next strobe occurs no earlier than 2 cycles later (IDLE, then ISSUE).
- All outputs are registered, except cmd_ready_o, which is decoded from the registered count.

## Structure
- Shared package xmpl_loongson_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - ADDR_W = 12, DATA_W = 32.
  - STATUS_DONE_BIT = 0.
- Sub-module xmpl_loongson_cmd_fifo, parameterised by width and depth: synchronous FIFO with full, empty and count outputs.
- The FSM, timer and response registers live in the top module.

## Test plan
- Single command: push addr 0x0A5, data 0xDEADBEEF; core raises done 3 cycles after the strobe with status 0x00000013 -> b/c = 0x0A5/0xDEADBEEF; a_o high exactly 1 cycle, 2 cycles after the push; rsp_status_o = 0x00000013; rsp_timeout_o = 0.
- Timeout: TIMEOUT = 8, core never raises done -> rsp_valid_o rises 9 cycles after the strobe; rsp_timeout_o = 1; rsp_status_o = 0.
- FIFO full: FIFO_DEPTH = 4, core stalled, push 6 commands back-to-back -> cmd_ready_o drops after the 5th accept (1 in flight, 4 buffered). The 6th is held and accepted after the first response. All 6 are issued in order.
- Response backpressure: hold rsp_ready_i = 0 for 10 cycles -> rsp_valid_o, rsp_status_o and rsp_timeout_o stay stable; no new strobe until the handshake completes.
- Done on the timeout cycle: TIMEOUT = 4, done asserted in the 4th WAIT cycle -> rsp_timeout_o = 0 and the status is captured.
- Async reset in WAIT: assert reset_n_i mid-cycle -> all outputs take their reset values immediately; no response afterwards; a new command issues normally after release.
